// File: rtl/port_host_link_if.sv
// ============================================================
// Module  : port_host_link_if
// Brief   : Port/host bundle between the ARM7 parallel ports and the host
// Revision: 1.0
// ============================================================
`default_nettype none

interface port_host_link_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int c_CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] OUTPORT;
  logic [WIDTH-1:0] INPORT;
  logic [WIDTH-1:0] host_in_data;
  logic             host_in_load;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             overflow;
  logic             ovf_clr;
  logic [c_CW-1:0]  count;

  // The link endpoint itself
  modport slave (
    input  OUTPORT, host_in_data, host_in_load, out_ready, ovf_clr,
    output INPORT, out_data, out_valid, overflow, count
  );

  // Core plus host side driving the link
  modport master (
    output OUTPORT, host_in_data, host_in_load, out_ready, ovf_clr,
    input  INPORT, out_data, out_valid, overflow, count
  );
endinterface

`default_nettype wire

// File: rtl/port_host_link.sv
// ============================================================
// Module  : port_host_link
// Brief   : Queues OUTPORT changes for the host, holds the INPORT value
// Revision: 1.0
// ============================================================
`default_nettype none

module port_host_link #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  port_host_link_if.slave      bus
);

  localparam int              c_AW      = $clog2(DEPTH);
  localparam int              c_CW      = c_AW + 1;
  localparam logic [c_CW-1:0] c_FULL    = c_CW'(DEPTH);
  localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
  localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_CW-1:0]  r_count;
  logic [WIDTH-1:0] r_last_out;
  logic [WIDTH-1:0] r_inport;
  logic             r_overflow;

  logic w_change;
  logic w_full;
  logic w_pop;
  logic w_store;
  logic w_drop;

  always_comb begin
    w_change = (bus.OUTPORT != r_last_out);
    w_full   = (r_count == c_FULL);
    w_pop    = (r_count != '0) && bus.out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    w_store  = w_change && (!w_full || w_pop);
    w_drop   = w_change && w_full && !w_pop;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_last_out <= '0;
      r_inport   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_last_out <= bus.OUTPORT;

      if (w_store) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end

      if (w_store && !w_pop) begin
        r_count <= r_count + c_CNT_ONE;
      end else if (w_pop && !w_store) begin
        r_count <= r_count - c_CNT_ONE;
      end

      // Setting beats clearing when both happen together
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (bus.ovf_clr) begin
        r_overflow <= 1'b0;
      end

      if (bus.host_in_load) begin
        r_inport <= bus.host_in_data;
      end
    end
  end

  // Storage needs no reset: entries are only visible through r_count
  always_ff @(posedge clk) begin
    if (rst && w_store) begin
      r_mem[r_wr_ptr] <= bus.OUTPORT;
    end
  end

  assign bus.out_data  = r_mem[r_rd_ptr];
  assign bus.out_valid = (r_count != '0);
  assign bus.count     = r_count;
  assign bus.overflow  = r_overflow;
  assign bus.INPORT    = r_inport;

endmodule

`default_nettype wire

// File: doc/port_host_link.md
# port_host_link

Host-side endpoint for the ARM7 core's 8-bit parallel ports. It watches `OUTPORT` for value changes and queues each new value into a small FIFO, which an external host drains through a valid/ready handshake. It also holds the value driven onto the core's `INPORT`, loaded by the host with a one-cycle strobe. It sits between the `ARM7` top level and the bench or host logic, and replaces ad-hoc polling of `OUTPORT`.

## Interface
Parameters:
- `WIDTH`, 8: port width in bits.
- `DEPTH`, 4: FIFO entries. Must be a power of 2 and at least 2.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-low.
- `OUTPORT` input WIDTH: core output port, sampled every cycle.
- `INPORT` output WIDTH: core input port, driven from the holding register.
- `host_in_data` input WIDTH: value for `INPORT`.
- `host_in_load` input 1: when high, loads `host_in_data` into the `INPORT` register.
- `out_data` output WIDTH: FIFO head entry. Valid only while `out_valid` is high.
- `out_valid` output 1: FIFO not empty.
- `out_ready` input 1: host accepts the head entry this cycle.
- `overflow` output 1: sticky flag, set when a change was dropped because the FIFO was full.
- `ovf_clr` input 1: clears `overflow`.
- `count` output log2(DEPTH)+1: current FIFO occupancy.

## Operation
- The `last_out` register holds the most recently sampled `OUTPORT` value.
- Change detect (push):
  - Each edge with `rst`=1 and `OUTPORT != last_out` generates a push of `OUTPORT`.
  - `last_out` takes `OUTPORT` on every such edge, whether or not the push is stored.
- Pop: occurs when `out_valid && out_ready`. Asserting `out_ready` while empty has no effect.
- Push and pop in the same cycle:
  - Both take effect.
  - `count` is unchanged.
  - This holds even when the FIFO is full: the pop frees the slot, so the push is stored and no overflow is raised.
- Full with push and no pop: the value is dropped, `overflow` sets to 1, and FIFO contents are unchanged.
- `overflow` is cleared by `ovf_clr`. If a set and `ovf_clr` occur in the same cycle, set wins.
- FIFO structure:
  - Circular buffer with read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH.
  - `count` is a separate counter ranging 0..DEPTH.
  - `out_data` = `mem[rd_ptr]` (first-word fall-through, no extra read latency).
- `INPORT` register: loads `host_in_data` on an edge with `host_in_load`=1, otherwise holds. It is independent of the FIFO.
- Reset (`rst`=0 at an edge), taking priority over every other input:
  - `last_out`=0, `INPORT`=0, `overflow`=0, `count`=0, both pointers 0.
  - `out_valid`=0. `out_data` is don't-care while `out_valid`=0.
  - Any entries in flight when reset is asserted mid-operation are discarded.
  - After reset, an `OUTPORT` value of 0 produces no entry. The first nonzero value does.

## Timing
- Push latency: a change present before edge N is stored at edge N, and `out_valid`=1 after edge N, one cycle after `OUTPORT` changes.
- Pop: at the edge where `out_valid && out_ready` is seen, the head advances. The next entry, or `out_valid`=0, is visible after that edge.
- Multi-cycle stability: `OUTPORT` held constant for many cycles yields exactly one entry.
- Back-to-back changes: changes on consecutive cycles yield one entry per cycle.
- `overflow` rises the cycle after the dropped push.
- `INPORT` updates the cycle after `host_in_load`. The core sees the new value from that cycle onward.
- All outputs are registered or derived from registers only. There is no combinational path from inputs to outputs.

## Test plan
- Reset and idle: hold `rst`=0 for 3 edges, then release with `OUTPORT`=0x00 for 10 cycles -> `out_valid`=0, `count`=0, `INPORT`=0x00, `overflow`=0 throughout.
- Single change: set `OUTPORT`=0x5A for 8 cycles with `out_ready`=0 -> exactly one entry. `out_valid`=1 from the next edge, `out_data`=0x5A, `count`=1. Then pulse `out_ready` for 1 cycle -> `count`=0, `out_valid`=0.
- Fill and overflow: drive 0x01, 0x02, 0x03, 0x04, 0x05 on consecutive cycles with `out_ready`=0 -> `count`=4 and `overflow`=1 after the 5th. Then drain -> 0x01, 0x02, 0x03, 0x04 in order, then `out_valid`=0. Then pulse `ovf_clr` -> `overflow`=0.
- Full, simultaneous push/pop: with the FIFO full of 0x11..0x14, drive `OUTPORT`=0x20 with `out_ready`=1 in the same cycle -> `count` stays 4 and `overflow` stays 0. The drain sequence is then 0x12, 0x13, 0x14, 0x20.
- Pointer wrap: stream 10 distinct values with `out_ready` held at 1 -> each appears on `out_data` one cycle after its change, in order, with `count` never above 1.
- INPORT load and reset mid-operation: pulse `host_in_load` with `host_in_data`=0xC3 -> `INPORT`=0xC3 the next cycle. With 3 entries queued, assert `rst`=0 for one edge -> `count`=0, `INPORT`=0x00, `overflow`=0. The old `OUTPORT` value, if nonzero, is re-queued after release.
